kab_uart_rx: RTL
================

// Module: kab_uart_rx
// PURPOSE
//   UART receive front end in the IO clock domain, fed directly by the chip's Rxd pin.
//   Synchronises and oversamples the line, then deframes 8N1 characters (optional even parity).
//   Buffers received bytes in a small FIFO for the KabIO register/interrupt logic, and reports sticky error flags.
// PARAMETERS
//   OVS_DIV     27  IO_Clock cycles per 1/16-bit tick (50 MHz / 115200 / 16); legal range >= 2
//   FIFO_DEPTH  4   receive FIFO entries; power of two, >= 2
// PORTS
//   IO_Clock     in   1  IO clock; all logic on its rising edge
//   IO_Reset     in   1  asynchronous, active-high reset
//   Rxd          in   1  raw serial line from pin; idle high
//   Rx_RdEn      in   1  pop FIFO head (one entry per cycle asserted)
//   Rx_ErrClr    in   1  clear all sticky error flags
//   Rx_Data      out  8  FIFO head byte; valid only when Rx_Valid=1
//   Rx_Valid     out  1  FIFO not empty; doubles as level interrupt request
//   Rx_Full      out  1  FIFO holds FIFO_DEPTH entries
//   Rx_FrameErr  out  1  sticky: stop bit sampled 0
//   Rx_Overrun   out  1  sticky: byte completed while FIFO full
//   Rx_ParityErr out  1  sticky: parity mismatch (tied 0 without KAB_UART_PARITY_EN)
// BEHAVIOUR
//   - Reset: all outputs 0, FIFO empty, synchroniser flops = 1, FSM = WAIT_HIGH.
//   - Rxd passes through a 2-flop synchroniser (rxs); all decisions use rxs.
//   - Tick counter: counts 0..OVS_DIV-1 and pulses at OVS_DIV-1. Cleared on start detect. Runs only outside IDLE/WAIT_HIGH.
//   - Bit phase counter: 0..15, advanced per tick. Bit value = majority of samples at phases 7, 8, 9, decided at phase 9.
//   - FSM states and transitions:
//     - WAIT_HIGH -> IDLE when rxs=1.
//     - IDLE -> START when rxs=0; tick and phase counters cleared.
//     - START: at phase 9, majority 1 (glitch) -> IDLE; else at phase 15 -> DATA.
//     - DATA: 8 bits, LSB first, shifted at phase 9; after bit 7 phase 15 -> PARITY (if enabled) or STOP.
//     - PARITY: at phase 9 compare with even parity of the data byte; result held; at phase 15 -> STOP.
//     - STOP at phase 9, evaluated in this order:
//       - majority 0: FrameErr<=1, byte dropped, -> WAIT_HIGH.
//       - parity bad: ParityErr<=1, byte dropped, -> IDLE.
//       - otherwise: push byte, -> IDLE. IDLE is entered mid stop bit so a back-to-back start edge is caught.
//   - Push latency: byte visible on Rx_Data/Rx_Valid the cycle after the stop-bit decision.
//   - FIFO behaviour:
//     - Rx_Data = mem[rd_ptr]; memory reset to 0.
//     - Pop when empty is ignored.
//     - Push when full without pop: byte dropped, Overrun<=1, contents intact.
//     - Push and pop in the same cycle when full: both succeed, no overrun.
//     - Push and pop in the same cycle when empty: push only; Rx_Valid=1 next cycle.
//     - Pointers are log2(FIFO_DEPTH)+1 bits with a wrap bit; full/empty derived from the pointers.
//   - Flags: error set and Rx_ErrClr in the same cycle -> set wins. Flags are never cleared by a pop.
//   - Reset mid-frame aborts the partial byte. After reset the FSM waits for the line high, so a held-low line produces no bytes.
// CONFIGURATION
//   KAB_UART_PARITY_EN defined:
//     - PARITY state is present; frame is 8E1.
//     - A mismatch sets Rx_ParityErr and drops the byte.
//   KAB_UART_PARITY_EN undefined:
//     - 8N1; PARITY state is not generated.
//     - Rx_ParityErr is a constant 0; port list unchanged.
// STRUCTURE
//   - Package kab_uart_pkg holds:
//     - state enum: WAIT_HIGH, IDLE, START, DATA, PARITY, STOP
//     - OVS_RATE=16, SAMPLE_MID=9, DATA_BITS=8
//   - One sub-module: kab_byte_fifo (sync FIFO, params WIDTH/DEPTH, push/pop/full/empty/head).
//   - Synchroniser, tick counter and FSM stay in kab_uart_rx.
// TESTING (bench uses OVS_DIV=4, i.e. 64 cycles/bit)
//   1. Hold Rxd=0 through and 500 cycles past reset; then 1; send 0x55 -> no byte during low; then Rx_Valid=1, Rx_Data=0x55.
//   2. Send 0xA5,0x3C,0x0F,0xF0,0x81 without popping:
//      - Rx_Full=1, Rx_Overrun=1.
//      - Pops return 0xA5,0x3C,0x0F,0xF0, then Rx_Valid=0.
//   3. Send 0x12 with stop bit 0 -> Rx_FrameErr=1, FIFO empty; pulse Rx_ErrClr -> 0; following 0x34 received normally.
//   4. Rxd low for 5 ticks (20 cycles), then high -> no byte, no flag; the next frame 0x7E is received correctly.
//   5. FIFO full; assert Rx_RdEn on the push cycle of 0x99 -> no overrun; 0x99 at tail, depth stays 4.
//   6. Parity, with macro: 0x03 + parity 1 -> Rx_ParityErr=1, no byte; 0x03 + parity 0 -> accepted.
//      Parity, without macro: 0x03 at 8N1 -> accepted, Rx_ParityErr=0.

Source files
------------

// File: rtl/kab_uart_pkg.sv
// Shared types and constants for the KabIO UART receive path.
package kab_uart_pkg;

  typedef enum logic [2:0] {
    WAIT_HIGH,
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  localparam int OVS_RATE   = 16;
  localparam int SAMPLE_MID = 9;
  localparam int DATA_BITS  = 8;

endpackage

// File: rtl/kab_byte_fifo.sv
// Small synchronous FIFO; head is combinational from the read pointer.
module kab_byte_fifo
  import kab_uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_pop;
  logic             do_push;

  // Extra MSB on each pointer tells full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head    = mem[rd_ptr[AW-1:0]];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/kab_uart_rx.sv
// UART receiver: 2-flop sync, 16x oversampled 8N1/8E1 deframer, byte FIFO, sticky errors.
// Define KAB_UART_PARITY_EN for 8E1 framing with parity checking; default is 8N1.
module kab_uart_rx
  import kab_uart_pkg::*;
#(
  parameter int OVS_DIV    = 27,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       IO_Clock,
  input  logic       IO_Reset,
  input  logic       Rxd,
  input  logic       Rx_RdEn,
  input  logic       Rx_ErrClr,
  output logic [7:0] Rx_Data,
  output logic       Rx_Valid,
  output logic       Rx_Full,
  output logic       Rx_FrameErr,
  output logic       Rx_Overrun,
  output logic       Rx_ParityErr
);

  localparam int TICK_W = (OVS_DIV > 1) ? $clog2(OVS_DIV) : 1;
  localparam int PH_W   = $clog2(OVS_RATE);
  localparam int BIT_W  = $clog2(DATA_BITS);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVS_DIV - 1);
  localparam logic [PH_W-1:0]   PH_S7     = PH_W'(SAMPLE_MID - 2);
  localparam logic [PH_W-1:0]   PH_S8     = PH_W'(SAMPLE_MID - 1);
  localparam logic [PH_W-1:0]   PH_MID    = PH_W'(SAMPLE_MID);
  localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(OVS_RATE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  rx_state_e              state;
  rx_state_e              state_nxt;
  logic                   rxs_p0;
  logic                   rxs;
  logic                   vld_p0;
  logic                   vld_p1;
  logic [TICK_W-1:0]      tick_cnt;
  logic [PH_W-1:0]        phase;
  logic [BIT_W-1:0]       bit_idx;
  logic [DATA_BITS-1:0]   shreg;
  logic                   s7;
  logic                   s8;
  logic                   running;
  logic                   tick;
  logic                   at_mid;
  logic                   at_last;
  logic                   maj;
  logic                   start_det;
  logic                   push;
  logic                   fe_set;
  logic                   ov_set;
  logic                   fifo_full;
  logic                   fifo_empty;
`ifdef KAB_UART_PARITY_EN
  logic                   par_bad;
  logic                   pe_set;
  logic                   parity_err;
`endif

  // ---- stage p0/p1: line synchroniser ----
  // The sync flops reset to 1, so their first outputs are not line samples;
  // vld_p1 marks when rxs first reflects the pin, which keeps a line held low
  // through reset from looking like an idle-then-start sequence.
  always_ff @(posedge IO_Clock or posedge IO_Reset) begin
    if (IO_Reset) begin
      rxs_p0 <= 1'b1;
      rxs    <= 1'b1;
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      rxs_p0 <= Rxd;
      rxs    <= rxs_p0;
      vld_p0 <= 1'b1;
      vld_p1 <= vld_p0;
    end
  end

  // ---- oversampling timebase ----
  assign running = (state != IDLE) && (state != WAIT_HIGH);
  assign tick    = running && (tick_cnt == TICK_LAST);
  assign at_mid  = tick && (phase == PH_MID);
  assign at_last = tick && (phase == PH_LAST);
  assign maj     = majority3(s7, s8, rxs);

  always_ff @(posedge IO_Clock or posedge IO_Reset) begin
    if (IO_Reset) begin
      tick_cnt <= '0;
      phase    <= '0;
      bit_idx  <= '0;
    end else begin
      if (!running || tick) tick_cnt <= '0;
      else                  tick_cnt <= tick_cnt + TICK_W'(1);
      if (start_det)        phase <= '0;
      else if (tick)        phase <= phase + PH_W'(1);
      if (start_det)                       bit_idx <= '0;
      else if ((state == DATA) && at_last) bit_idx <= bit_idx + BIT_W'(1);
    end
  end

  // Sample and shift registers carry data only; every use is qualified by the FSM.
  always_ff @(posedge IO_Clock) begin
    if (tick && (phase == PH_S7)) s7 <= rxs;
    if (tick && (phase == PH_S8)) s8 <= rxs;
    if ((state == DATA) && at_mid) shreg <= {maj, shreg[DATA_BITS-1:1]};
`ifdef KAB_UART_PARITY_EN
    if ((state == PARITY) && at_mid) par_bad <= maj ^ (^shreg);
`endif
  end

  // ---- deframing FSM ----
  always_ff @(posedge IO_Clock or posedge IO_Reset) begin
    if (IO_Reset) state <= WAIT_HIGH;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start_det = 1'b0;
    push      = 1'b0;
    fe_set    = 1'b0;
`ifdef KAB_UART_PARITY_EN
    pe_set    = 1'b0;
`endif
    case (state)
      WAIT_HIGH: if (vld_p1 && rxs) state_nxt = IDLE;
      IDLE: begin
        if (!rxs) begin
          state_nxt = START;
          start_det = 1'b1;
        end
      end
      START: begin
        if (at_mid && maj) state_nxt = IDLE;
        else if (at_last)  state_nxt = DATA;
      end
      DATA: begin
        if (at_last && (bit_idx == BIT_LAST)) begin
`ifdef KAB_UART_PARITY_EN
          state_nxt = PARITY;
`else
          state_nxt = STOP;
`endif
        end
      end
`ifdef KAB_UART_PARITY_EN
      PARITY: if (at_last) state_nxt = STOP;
`endif
      STOP: begin
        // Leave at mid stop bit so a back-to-back start edge is not missed.
        if (at_mid) begin
          if (!maj) begin
            fe_set    = 1'b1;
            state_nxt = WAIT_HIGH;
`ifdef KAB_UART_PARITY_EN
          end else if (par_bad) begin
            pe_set    = 1'b1;
            state_nxt = IDLE;
`endif
          end else begin
            push      = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = WAIT_HIGH;
    endcase
  end

  // ---- receive buffer and sticky flags ----
  assign ov_set = push && fifo_full && !Rx_RdEn;

  kab_byte_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (IO_Clock),
    .rst   (IO_Reset),
    .push  (push),
    .pop   (Rx_RdEn),
    .din   (shreg),
    .head  (Rx_Data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign Rx_Valid = !fifo_empty;
  assign Rx_Full  = fifo_full;

  always_ff @(posedge IO_Clock or posedge IO_Reset) begin
    if (IO_Reset) begin
      Rx_FrameErr <= 1'b0;
      Rx_Overrun  <= 1'b0;
    end else begin
      if (fe_set)         Rx_FrameErr <= 1'b1;
      else if (Rx_ErrClr) Rx_FrameErr <= 1'b0;
      if (ov_set)         Rx_Overrun  <= 1'b1;
      else if (Rx_ErrClr) Rx_Overrun  <= 1'b0;
    end
  end

`ifdef KAB_UART_PARITY_EN
  always_ff @(posedge IO_Clock or posedge IO_Reset) begin
    if (IO_Reset)       parity_err <= 1'b0;
    else if (pe_set)    parity_err <= 1'b1;
    else if (Rx_ErrClr) parity_err <= 1'b0;
  end
  assign Rx_ParityErr = parity_err;
`else
  assign Rx_ParityErr = 1'b0;
`endif

endmodule
